// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver.
// The serial line is synchronized, the start bit is qualified at half-bit,
// and each data/stop bit is sampled one full bit period after the previous one.
// Good frames update data_out with a one-cycle rx_done pulse. A low stop bit
// gives a one-cycle frame_err pulse and parks the receiver until the line
// returns high, so that a held-low line (break) cannot start spurious frames.
module uart_rx #(
    parameter int CLKS_PER_BIT = 501
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rxd,
    output logic [7:0] data_out,
    output logic       rx_done,
    output logic       frame_err,
    output logic       rx_busy
);

    localparam int HALF_BIT = CLKS_PER_BIT / 2;
    localparam int CNT_W    = $clog2(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0] CNT_ZERO      = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE       = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_HALF_LAST = CNT_W'(HALF_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    state_t           state_q,     state_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic [2:0]       idx_q,       idx_d;
    logic [7:0]       shift_q,     shift_d;
    logic [7:0]       data_out_q,  data_out_d;
    logic             rx_done_q,   rx_done_d;
    logic             frame_err_q, frame_err_d;
    logic             rx_busy_q,   rx_busy_d;
    logic             sync1_q,     sync1_d;
    logic             sync2_q,     sync2_d;
    logic             rxd_s;

    assign rxd_s     = sync2_q;
    assign data_out  = data_out_q;
    assign rx_done   = rx_done_q;
    assign frame_err = frame_err_q;
    assign rx_busy   = rx_busy_q;

    // Synchronizer inputs: the line moves one flop per clock.
    always_comb begin
        sync1_d = rxd;
        sync2_d = sync1_q;
    end

    // Two-flop synchronizer; resets to the idle-high line level.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    // Next-state logic: bit timing, shifting, and the one-cycle result pulses.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        shift_d     = shift_q;
        data_out_d  = data_out_q;
        rx_done_d   = 1'b0;
        frame_err_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_d = CNT_ZERO;
                if (!rxd_s) begin
                    state_d = S_START;
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_START: begin
                if (cnt_q == CNT_HALF_LAST) begin
                    cnt_d = CNT_ZERO;
                    idx_d = 3'd0;
                    if (!rxd_s) begin
                        state_d = S_DATA;
                    end else begin
                        // Line went back high before mid start bit: a glitch.
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            S_DATA: begin
                if (cnt_q == CNT_BIT_LAST) begin
                    cnt_d          = CNT_ZERO;
                    shift_d[idx_q] = rxd_s;
                    if (idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            S_STOP: begin
                if (cnt_q == CNT_BIT_LAST) begin
                    cnt_d = CNT_ZERO;
                    if (rxd_s) begin
                        data_out_d = shift_q;
                        rx_done_d  = 1'b1;
                        state_d    = S_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = S_BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            S_BREAK: begin
                cnt_d = CNT_ZERO;
                if (rxd_s) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_BREAK;
                end
            end

            default: begin
                state_d = S_IDLE;
                cnt_d   = CNT_ZERO;
                idx_d   = 3'd0;
            end
        endcase

        rx_busy_d = (state_d != S_IDLE);
    end

    // Receiver state and registered outputs; reset abandons any frame silently.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= CNT_ZERO;
            idx_q       <= 3'd0;
            shift_q     <= 8'h00;
            data_out_q  <= 8'h00;
            rx_done_q   <= 1'b0;
            frame_err_q <= 1'b0;
            rx_busy_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            data_out_q  <= data_out_d;
            rx_done_q   <= rx_done_d;
            frame_err_q <= frame_err_d;
            rx_busy_q   <= rx_busy_d;
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: drives 8N1 frames into uart_rx and compares every rx_done /
// frame_err pulse (kind, data_out, cycle) with a waveform-level reference
// model that applies the mid-bit sample-point rules to the recorded line.
module tb_uart_rx;

    localparam int CPB  = 16;
    localparam int HALF = CPB / 2;

    logic       clk;
    logic       reset;
    logic       rxd;
    logic [7:0] data_out;
    logic       rx_done;
    logic       frame_err;
    logic       rx_busy;

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk      (clk),
        .reset    (reset),
        .rxd      (rxd),
        .data_out (data_out),
        .rx_done  (rx_done),
        .frame_err(frame_err),
        .rx_busy  (rx_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // kind: {frame_err, rx_done}; at: index of the rising edge that set it
    typedef struct packed {
        logic [1:0]  kind;
        logic [7:0]  data;
        logic [31:0] at;
    } ev_t;

    logic       wave[$];   // rxd value at each rising edge since clear_log
    ev_t        obs[$];    // observed pulses
    ev_t        exp_q[$];  // model pulses
    logic [7:0] last_good;
    int         vectors     = 0;
    int         miscompares = 0;

    function automatic ev_t mk_ev(input logic [1:0] k, input logic [7:0] d, input int at);
        ev_t e;
        e.kind = k;
        e.data = d;
        e.at   = 32'(at);
        return e;
    endfunction

    // record the line as the receiver's first flop sees it
    always @(posedge clk) wave.push_back(rxd);

    // record every output pulse, sampled mid-cycle
    always @(negedge clk) begin
        if (rx_done || frame_err) obs.push_back(mk_ev({frame_err, rx_done}, data_out, wave.size() - 1));
    end

    // Reference: scan the line for start edges and read bits at HALF + j*CPB
    // after the first low sample; the receiver reports two edges later
    // (synchronizer) and resumes hunting right after its last sample.
    task automatic run_model();
        int         i;
        int         n;
        int         st;
        logic [7:0] b;
        exp_q.delete();
        n = wave.size();
        i = 0;
        while (i < n) begin
            if (wave[i]) begin
                i = i + 1;
            end else if (i + HALF + 9 * CPB + 2 >= n) begin
                i = n;
            end else if (wave[i + HALF]) begin
                i = i + HALF + 1;
            end else begin
                st = i + HALF + 9 * CPB;
                for (int k = 0; k < 8; k++) b[k] = wave[i + HALF + (k + 1) * CPB];
                if (wave[st]) begin
                    last_good = b;
                    exp_q.push_back(mk_ev(2'b01, b, st + 2));
                    i = st + 1;
                end else begin
                    exp_q.push_back(mk_ev(2'b10, last_good, st + 2));
                    i = st + 1;
                    while (i < n && !wave[i]) i = i + 1;
                    i = i + 1;
                end
            end
        end
    endtask

    task automatic drive_level(input logic v, input int n);
        rxd = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        drive_level(1'b1, n);
    endtask

    task automatic send_bits(input logic [7:0] d, input int bc);
        drive_level(1'b0, bc);
        for (int k = 0; k < 8; k++) drive_level(d[k], bc);
    endtask

    task automatic send_frame(input logic [7:0] d, input int bc);
        send_bits(d, bc);
        drive_level(1'b1, bc);
    endtask

    task automatic clear_log();
        wave.delete();
        obs.delete();
    endtask

    task automatic close_segment();
        @(negedge clk);
        run_model();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        rxd   = 1'b1;
        #1;
        vectors++;
        if ({data_out, rx_done, frame_err, rx_busy} !== 11'h000) begin
            miscompares++;
            $display("FAIL reset_async: outputs=%h required 000", {data_out, rx_done, frame_err, rx_busy});
        end
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({data_out, rx_done, frame_err, rx_busy} !== 11'h000) begin
            miscompares++;
            $display("FAIL reset_hold: outputs=%h required 000", {data_out, rx_done, frame_err, rx_busy});
        end
        reset     = 1'b1;
        last_good = 8'h00;
        idle(6);
    endtask

    task automatic test_basic();
        clear_log();
        send_frame(8'hA5, CPB);
        idle(30);
        close_segment();
        vectors++;
        if (obs.size() != exp_q.size()) begin
            miscompares++;
            $display("FAIL basic_count: %0d pulses seen, %0d required", obs.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
            vectors++;
            if (obs[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL basic_pulse%0d: got %h required %h", i, obs[i], exp_q[i]);
            end
        end
        vectors++;
        if (obs.size() != 1 || data_out !== 8'hA5 || rx_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_a5: pulses=%0d data_out=%h busy=%b required 1 a5 0", obs.size(), data_out, rx_busy);
        end
    endtask

    task automatic test_glitch();
        idle(4);
        clear_log();
        drive_level(1'b0, 4);
        idle(20);
        vectors++;
        if (rx_busy !== 1'b0 || obs.size() != 0) begin
            miscompares++;
            $display("FAIL glitch_abort: busy=%b pulses=%0d required 0 0", rx_busy, obs.size());
        end
        send_frame(8'h5A, CPB);
        idle(30);
        close_segment();
        vectors++;
        if (obs.size() != exp_q.size()) begin
            miscompares++;
            $display("FAIL glitch_count: %0d pulses seen, %0d required", obs.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
            vectors++;
            if (obs[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL glitch_pulse%0d: got %h required %h", i, obs[i], exp_q[i]);
            end
        end
        vectors++;
        if (data_out !== 8'h5A) begin
            miscompares++;
            $display("FAIL glitch_5a: data_out=%h required 5a", data_out);
        end
    endtask

    task automatic test_framing();
        idle(4);
        clear_log();
        send_frame(8'h11, CPB);
        idle(10);
        send_bits(8'h3C, CPB);
        drive_level(1'b0, 35);
        vectors++;
        if (rx_busy !== 1'b1 || data_out !== 8'h11) begin
            miscompares++;
            $display("FAIL framing_break: busy=%b data_out=%h required 1 11", rx_busy, data_out);
        end
        drive_level(1'b0, 5);
        idle(20);
        send_frame(8'h7E, CPB);
        idle(30);
        close_segment();
        vectors++;
        if (obs.size() != exp_q.size()) begin
            miscompares++;
            $display("FAIL framing_count: %0d pulses seen, %0d required", obs.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
            vectors++;
            if (obs[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL framing_pulse%0d: got %h required %h", i, obs[i], exp_q[i]);
            end
        end
        vectors++;
        if (data_out !== 8'h7E) begin
            miscompares++;
            $display("FAIL framing_7e: data_out=%h required 7e", data_out);
        end
    endtask

    task automatic test_back_to_back();
        idle(4);
        clear_log();
        send_frame(8'h00, CPB);
        send_frame(8'hFF, CPB);
        send_frame(8'h81, CPB);
        idle(30);
        close_segment();
        vectors++;
        if (obs.size() != exp_q.size()) begin
            miscompares++;
            $display("FAIL b2b_count: %0d pulses seen, %0d required", obs.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
            vectors++;
            if (obs[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL b2b_pulse%0d: got %h required %h", i, obs[i], exp_q[i]);
            end
        end
        vectors++;
        if (obs.size() != 3 || {obs[0].data, obs[1].data, obs[2].data} !== 24'h00FF81) begin
            miscompares++;
            $display("FAIL b2b_order: %0d pulses, last data_out=%h required 3 pulses 00 ff 81", obs.size(), data_out);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] d;
        d = 8'hC3;
        idle(4);
        clear_log();
        drive_level(1'b0, CPB);
        for (int k = 0; k < 4; k++) drive_level(d[k], CPB);
        drive_level(d[4], 5);
        #2 reset = 1'b0;
        #1;
        vectors++;
        if ({data_out, rx_done, frame_err, rx_busy} !== 11'h000) begin
            miscompares++;
            $display("FAIL midreset_async: outputs=%h required 000", {data_out, rx_done, frame_err, rx_busy});
        end
        rxd = 1'b1;
        repeat (4) @(posedge clk);
        #1 reset = 1'b1;
        last_good = 8'h00;
        idle(4);
        clear_log();
        idle(30);
        send_frame(8'h42, CPB);
        idle(30);
        close_segment();
        vectors++;
        if (obs.size() != exp_q.size()) begin
            miscompares++;
            $display("FAIL midreset_count: %0d pulses seen, %0d required", obs.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
            vectors++;
            if (obs[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL midreset_pulse%0d: got %h required %h", i, obs[i], exp_q[i]);
            end
        end
        vectors++;
        if (obs.size() != 1 || data_out !== 8'h42) begin
            miscompares++;
            $display("FAIL midreset_42: pulses=%0d data_out=%h required 1 42", obs.size(), data_out);
        end
    endtask

    // Off-rate senders: the expected byte and stop result are whatever the
    // fixed mid-bit sample points land on in the recorded line, since the
    // rate error accumulates across the frame.
    task automatic test_baud();
        int rates[2];
        rates[0] = CPB - 1;
        rates[1] = CPB + 1;
        for (int r = 0; r < 2; r++) begin
            idle(4);
            clear_log();
            send_frame(8'h96, rates[r]);
            idle(40);
            close_segment();
            vectors++;
            if (obs.size() != exp_q.size()) begin
                miscompares++;
                $display("FAIL baud%0d_count: %0d pulses seen, %0d required", rates[r], obs.size(), exp_q.size());
            end
            for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
                vectors++;
                if (obs[i] !== exp_q[i]) begin
                    miscompares++;
                    $display("FAIL baud%0d_pulse%0d: got %h required %h", rates[r], i, obs[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] d;
        idle(4);
        clear_log();
        for (int f = 0; f < 16; f++) begin
            d = 8'($urandom);
            send_bits(d, CPB);
            if ($urandom_range(0, 4) == 0) drive_level(1'b0, CPB + int'($urandom_range(0, 12)));
            else drive_level(1'b1, CPB);
            drive_level(1'b1, int'($urandom_range(0, 3)));
        end
        idle(40);
        close_segment();
        vectors++;
        if (obs.size() != exp_q.size()) begin
            miscompares++;
            $display("FAIL random_count: %0d pulses seen, %0d required", obs.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
            vectors++;
            if (obs[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL random_pulse%0d: got %h required %h", i, obs[i], exp_q[i]);
            end
        end
        vectors++;
        if (data_out !== last_good || rx_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL random_final: data_out=%h busy=%b required %h 0", data_out, rx_busy, last_good);
        end
    endtask

    initial begin
        reset = 1'b0;
        rxd   = 1'b1;
        test_reset();
        test_basic();
        test_glitch();
        test_framing();
        test_back_to_back();
        test_reset_mid_frame();
        test_baud();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
